fwnoc_egress_arb: RTL
=====================

Name: fwnoc_egress_arb

Overview:
Wormhole output-port arbiter for one egress direction of a fwnoc router. It shares a single 32-bit ready/valid egress channel among N_PORTS ingress requesters (N, S, E, W, host). It grants packets round-robin and locks the grant from the header flit through the tail flit, so packets from different requesters never interleave. One instance sits in front of each router egress port (ne_, se_, ee_, we_, he_).

Parameters:
N_PORTS, 5, number of requesting ingress ports; index 0..N_PORTS-1.
DAT_W, 32, flit width in bits.
LEN_LSB, 0, bit position of the payload-length field in the header flit.
LEN_W, 8, width of the payload-length field; it counts the payload flits that follow the header.

Ports:
clock  input  1  sole clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
i_valid  input  N_PORTS  per-requester flit valid.
i_ready  output  N_PORTS  per-requester flit accept.
i_dat  input  N_PORTS*DAT_W  per-requester flit data; requester k occupies [k*DAT_W +: DAT_W].
e_valid  output  1  egress flit valid.
e_ready  input  1  egress flit accept from the downstream ingress.
e_dat  output  DAT_W  egress flit data.
busy  output  1  high while a packet is locked (state LOCK).
owner  output  $clog2(N_PORTS)  index of the current or last granted requester.

Behaviour:
- A handshake on any channel occurs when valid && ready on a rising clock edge.
- State machine states:
  - IDLE: no packet is in flight; the next flit accepted is a header.
  - LOCK: payload flits of the owner's packet are in flight.
- State registers and reset values (asynchronous reset, applies immediately on reset assertion):
  - state = IDLE
  - rr_ptr = 0
  - remaining = 0 (LEN_W bits)
  - owner = 0
- Outputs during reset and with no requests:
  - e_valid = 0, i_ready = 0, busy = 0, e_dat = 0.
- IDLE, grant selection (combinational):
  - g is the first k with i_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo N_PORTS.
  - e_valid = i_valid[g], e_dat = i_dat[g].
  - i_ready[g] = e_ready; all other i_ready bits = 0.
  - The header passes through with zero cycles of latency.
  - If no i_valid is set: e_valid = 0 and e_dat = 0.
- IDLE, header handshake, let len = header[LEN_LSB +: LEN_W]:
  - owner <= g.
  - len == 0 (single-flit packet): stay in IDLE; rr_ptr <= (g+1) mod N_PORTS.
  - len != 0: go to LOCK; remaining <= len; rr_ptr is unchanged.
- LOCK:
  - Only the owner is connected: e_valid = i_valid[owner], e_dat = i_dat[owner], i_ready[owner] = e_ready.
  - All other i_ready bits = 0, regardless of their i_valid.
  - Each handshake decrements remaining by 1.
  - A handshake with remaining == 1 is the tail: go to IDLE, remaining <= 0, rr_ptr <= (owner+1) mod N_PORTS.
  - Owner deasserts i_valid mid-packet: e_valid = 0; the lock is held indefinitely with no timeout and no grant to others.
  - e_ready low: nothing advances and the state holds.
- Flits are forwarded unmodified; the header is not consumed.
- The block adds no buffering and no registered datapath. It has combinational paths i_valid→i_ready, e_ready→i_ready and i_dat→e_dat.
- Arbitration is performed only in IDLE. A request arriving during LOCK waits for the tail plus one arbitration.
- Fairness: after a packet from port k completes, port k has the lowest priority. A continuously requesting port therefore waits at most N_PORTS-1 packets.
- Back-to-back packets:
  - After the tail handshake, the next cycle is in IDLE and can grant a new header in that same cycle. No bubble is inserted.
  - A single-flit packet may follow another single-flit packet every cycle, rotating the grant.
- Reset asserted mid-packet: the state returns to IDLE and the partial packet is dropped. Upstream must also be reset.
- Length arithmetic: remaining is unsigned. The maximum packet is 2^LEN_W - 1 payload flits plus the header. There is no wrap or underflow because the decrement occurs only while remaining ≥ 1.
- busy = (state == LOCK).
- owner holds its value after the tail until the next header grant.

Test Plan:
1. Reset with all i_valid=1 → e_valid=0 and i_ready=0 during reset. After release, port 0 is granted first; owner=0.
2. Port 2 sends a header with len=3 plus 3 payload flits, e_ready=1 → 4 consecutive e_valid beats carrying the same data as input. busy is high from cycle 1 through the tail. After the tail, rr_ptr=3.
3. Ports 0, 1 and 4 each request continuously with single-flit packets (len=0) → grant order 0, 1, 4, 0, 1, 4, one flit per cycle, and busy stays 0.
4. Port 1 is locked with len=2 while port 3 raises a header → i_ready[3]=0 until port 1's tail. Port 3's header is granted in the cycle immediately after the tail.
5. During LOCK, the owner drops i_valid for 3 cycles, then e_ready toggles 1/0/1 → e_valid=0 in the gaps, remaining decrements only on handshakes, and the tail still exits on the correct flit.
6. Reset is asserted after 1 of 5 payload flits → busy=0 and state IDLE immediately. A fresh len=0 header from port 4 is granted after reset release.

Source files
------------

// File: rtl/fwnoc_egress_arb_if.sv
// rtl/fwnoc_egress_arb_if.sv - requester and egress flit channels of one egress arbiter
interface fwnoc_egress_arb_if #(
  parameter int N_PORTS = 5,
  parameter int DAT_W   = 32
);
  logic [N_PORTS-1:0]       i_valid;
  logic [N_PORTS-1:0]       i_ready;
  logic [N_PORTS*DAT_W-1:0] i_dat;
  logic                     e_valid;
  logic                     e_ready;
  logic [DAT_W-1:0]         e_dat;

  modport slave (
    input  i_valid, i_dat, e_ready,
    output i_ready, e_valid, e_dat
  );

  modport master (
    output i_valid, i_dat, e_ready,
    input  i_ready, e_valid, e_dat
  );
endinterface

// File: rtl/fwnoc_egress_arb.sv
// rtl/fwnoc_egress_arb.sv - wormhole round-robin arbiter for one router egress port
module fwnoc_egress_arb #(
  parameter int N_PORTS = 5,
  parameter int DAT_W   = 32,
  parameter int LEN_LSB = 0,
  parameter int LEN_W   = 8,
  localparam int OWN_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  fwnoc_egress_arb_if.slave  bus,
  output logic               busy,
  output logic [OWN_W-1:0]   owner
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_n;
  logic [OWN_W-1:0] rr_ptr, rr_n;
  logic [OWN_W-1:0] owner_n;
  logic [LEN_W-1:0] remaining, remaining_n;

  logic [OWN_W-1:0] gnt;
  logic             gnt_found;
  logic [OWN_W-1:0] sel;
  logic             active;
  logic             hs;
  logic [DAT_W-1:0] flit;
  logic [LEN_W-1:0] hdr_len;

  function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_PORTS) s = s - N_PORTS;
    return OWN_W'(s);
  endfunction

  // Round-robin search starting at rr_ptr; the first requester found wins.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!gnt_found && bus.i_valid[wrap_add(rr_ptr, i)]) begin
        gnt_found = 1'b1;
        gnt       = wrap_add(rr_ptr, i);
      end
    end
  end

  // Outputs are forced quiet while reset is held, even with requests pending.
  always_comb begin
    sel         = (state == LOCK) ? owner : gnt;
    active      = !reset && ((state == LOCK) || gnt_found);
    flit        = bus.i_dat[int'(sel)*DAT_W +: DAT_W];
    bus.e_valid = active && bus.i_valid[sel];
    bus.e_dat   = active ? flit : '0;
    bus.i_ready = '0;
    if (active) bus.i_ready[sel] = bus.e_ready;
    hs          = bus.e_valid && bus.e_ready;
    hdr_len     = flit[LEN_LSB +: LEN_W];
  end

  always_comb begin
    state_n     = state;
    rr_n        = rr_ptr;
    owner_n     = owner;
    remaining_n = remaining;
    case (state)
      IDLE: begin
        if (hs) begin
          owner_n = gnt;
          if (hdr_len == '0) begin
            rr_n = wrap_add(gnt, 1);
          end else begin
            state_n     = LOCK;
            remaining_n = hdr_len;
          end
        end
      end
      LOCK: begin
        if (hs) begin
          if (remaining == LEN_W'(1)) begin
            state_n     = IDLE;
            remaining_n = '0;
            rr_n        = wrap_add(owner, 1);
          end else begin
            remaining_n = remaining - LEN_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      remaining <= '0;
      owner     <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      remaining <= remaining_n;
      owner     <= owner_n;
    end
  end

  assign busy = (state == LOCK);

endmodule
